// File: rtl/wvr_vec_reader.sv
// Vector read sequencer: sweeps the register file read port and packs up to NWORDS words into one vector.
// Optional macro WVR_RD_REG_EN selects a registered (one-cycle latency) register-file read port.
module wvr_vec_reader #(
    parameter int NWORDS = 16,
    parameter int AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [1:0]            VL,
    input  logic [AW-1:0]         base,
    output logic [AW-1:0]         ra,
    input  logic [31:0]           rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NWORDS-1:0]  out_data,
    output logic                  out_err
);

    localparam int IW = $clog2(NWORDS) + 1;
    localparam int OW = $clog2(32 * NWORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_r;
    logic [1:0]            vl_r;
    logic [AW-1:0]         ra_r;
    logic [IW-1:0]         idx_r;
    logic                  out_valid_r;
    logic                  out_err_r;
    logic [32*NWORDS-1:0]  out_data_r;
    logic [IW-1:0]         len_s;
    logic [OW-1:0]         wr_off_s;

    function automatic logic [IW-1:0] vl_len(input logic [1:0] vl);
        case (vl)
            2'b00:   vl_len = IW'(1);
            2'b01:   vl_len = IW'(4);
            2'b10:   vl_len = IW'(NWORDS);
            default: vl_len = IW'(1);
        endcase
    endfunction

`ifdef WVR_RD_REG_EN
    // rd lags ra by one cycle, so captures follow issues through this pipe stage
    logic          cap_vld_r;
    logic [IW-1:0] cap_idx_r;

    // Bit offset of the word being captured, from the delayed capture index
    always_comb begin
        wr_off_s = {cap_idx_r[IW-2:0], 5'b00000};
    end
`else
    // Bit offset of the word being captured, from the issue index
    always_comb begin
        wr_off_s = {idx_r[IW-2:0], 5'b00000};
    end
`endif

    // Word count of the latched request
    always_comb begin
        len_s = vl_len(vl_r);
    end

    // Request acceptance, address sweep, packing and output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vl_r        <= 2'b00;
            ra_r        <= '0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            out_data_r  <= '0;
`ifdef WVR_RD_REG_EN
            cap_vld_r   <= 1'b0;
            cap_idx_r   <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_valid) begin
                        vl_r       <= VL;
                        ra_r       <= base;
                        idx_r      <= '0;
                        out_data_r <= '0;
`ifdef WVR_RD_REG_EN
                        cap_vld_r  <= 1'b0;
                        cap_idx_r  <= '0;
`endif
                        if (VL == 2'b11) begin
                            out_err_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            out_err_r <= 1'b0;
                            state_r   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
`ifdef WVR_RD_REG_EN
                    if (idx_r != len_s) begin
                        ra_r  <= ra_r + AW'(1);
                        idx_r <= idx_r + IW'(1);
                    end
                    cap_vld_r <= (idx_r != len_s);
                    cap_idx_r <= idx_r;
                    if (cap_vld_r) begin
                        out_data_r[wr_off_s +: 32] <= rd;
                        if (cap_idx_r == len_s - IW'(1)) begin
                            state_r <= ST_DONE;
                        end
                    end
`else
                    out_data_r[wr_off_s +: 32] <= rd;
                    ra_r  <= ra_r + AW'(1);
                    idx_r <= idx_r + IW'(1);
                    if (idx_r == len_s - IW'(1)) begin
                        state_r <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    // out_valid rises one cycle after entering DONE and drops on the handshake edge
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_r == ST_IDLE);
    assign ra          = ra_r;
    assign out_valid   = out_valid_r;
    assign out_err     = out_err_r;
    assign out_data    = out_data_r;

endmodule
